// File: rtl/window_gen_3x3_pkg.sv
// Shared constants for the 3x3 window generator and the downstream MAC.
package window_gen_3x3_pkg;

    localparam int KERNEL_SIZE    = 3;
    localparam int IMG_WIDTH_DEF  = 28;
    localparam int IMG_HEIGHT_DEF = 28;

    // Bits needed to count 0..n-1 (never less than one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/window_gen_3x3_line_buffer.sv
// One image row of pixel storage. The read is combinational on the same
// address that is written, so the returned value is the one stored before
// this cycle's write (read-before-write). No reset, so it maps onto RAM.
module window_gen_3x3_line_buffer
    import window_gen_3x3_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = IMG_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        i_we,
    input  logic [cnt_width(DEPTH)-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0]       i_wdata,
    output logic [DATA_WIDTH-1:0]       o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    // Store the incoming pixel at the current column.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end

endmodule

// File: rtl/window_gen_3x3.sv
// Raster-scan 3x3 sliding-window generator (valid padding, stride 1).
// Two chained line buffers hold the previous rows; a 3x3 register array
// shifts left by one column per accepted pixel.
module window_gen_3x3
    import window_gen_3x3_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] pix_in,
    input  logic                  pix_valid,
    input  logic                  pix_sof,
    output logic [DATA_WIDTH-1:0] img_r0_c0,
    output logic [DATA_WIDTH-1:0] img_r0_c1,
    output logic [DATA_WIDTH-1:0] img_r0_c2,
    output logic [DATA_WIDTH-1:0] img_r1_c0,
    output logic [DATA_WIDTH-1:0] img_r1_c1,
    output logic [DATA_WIDTH-1:0] img_r1_c2,
    output logic [DATA_WIDTH-1:0] img_r2_c0,
    output logic [DATA_WIDTH-1:0] img_r2_c1,
    output logic [DATA_WIDTH-1:0] img_r2_c2,
    output logic                  win_valid,
    output logic                  win_last
);

    localparam int CW = cnt_width(IMG_WIDTH);
    localparam int RW = cnt_width(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_FULL = CW'(KERNEL_SIZE - 1);
    localparam logic [RW-1:0] ROW_FULL = RW'(KERNEL_SIZE - 1);

    logic [CW-1:0] r_col, w_col, w_col_nxt;
    logic [RW-1:0] r_row, w_row, w_row_nxt;
    logic [DATA_WIDTH-1:0] w_lb0, w_lb1;
    logic w_win_ok, w_win_end;
    logic r_win_valid, r_win_last;
    // [row][col]; row 0 is the oldest line, col 0 the oldest column.
    logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][DATA_WIDTH-1:0] r_win;

    // Effective position of the incoming pixel (SOF forces 0,0) and the
    // position the counters advance to once it is accepted.
    always_comb begin
        w_col     = pix_sof ? '0 : r_col;
        w_row     = pix_sof ? '0 : r_row;
        w_col_nxt = w_col + CW'(1);
        w_row_nxt = w_row;
        if (w_col == COL_LAST) begin
            w_col_nxt = '0;
            w_row_nxt = (w_row == ROW_LAST) ? '0 : w_row + RW'(1);
        end
        w_win_ok  = (w_row >= ROW_FULL) && (w_col >= COL_FULL);
        w_win_end = (w_row == ROW_LAST) && (w_col == COL_LAST);
    end

    // lb0 holds the row above the current one, lb1 the row above that.
    window_gen_3x3_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb0 (
        .clk     (clk),
        .i_we    (pix_valid),
        .i_addr  (w_col),
        .i_wdata (pix_in),
        .o_rdata (w_lb0)
    );

    window_gen_3x3_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb1 (
        .clk     (clk),
        .i_we    (pix_valid),
        .i_addr  (w_col),
        .i_wdata (w_lb0),
        .o_rdata (w_lb1)
    );

    // Raster position counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_col <= '0;
            r_row <= '0;
        end else if (pix_valid) begin
            r_col <= w_col_nxt;
            r_row <= w_row_nxt;
        end
    end

    // Shift the window left and load the new column; flag complete windows.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_win       <= '0;
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
        end else begin
            r_win_valid <= pix_valid && w_win_ok;
            r_win_last  <= pix_valid && w_win_ok && w_win_end;
            if (pix_valid) begin
                for (int rr = 0; rr < KERNEL_SIZE; rr++)
                    for (int cc = 0; cc < KERNEL_SIZE - 1; cc++)
                        r_win[rr][cc] <= r_win[rr][cc+1];
                r_win[0][KERNEL_SIZE-1] <= w_lb1;
                r_win[1][KERNEL_SIZE-1] <= w_lb0;
                r_win[2][KERNEL_SIZE-1] <= pix_in;
            end
        end
    end

    assign img_r0_c0 = r_win[0][0];
    assign img_r0_c1 = r_win[0][1];
    assign img_r0_c2 = r_win[0][2];
    assign img_r1_c0 = r_win[1][0];
    assign img_r1_c1 = r_win[1][1];
    assign img_r1_c2 = r_win[1][2];
    assign img_r2_c0 = r_win[2][0];
    assign img_r2_c1 = r_win[2][1];
    assign img_r2_c2 = r_win[2][2];
    assign win_valid = r_win_valid;
    assign win_last  = r_win_last;

endmodule
